// File: rtl/regbank_param.sv
// Parametrised register file: two combinational read ports, one clocked write port,
// a self-sequencing clear engine with a ready flag, optional bypass and hardwired-zero r0.
module regbank_param #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              write,
    input  logic [ADDR_W-1:0] dr,
    input  logic [WIDTH-1:0]  wrData,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    output logic [WIDTH-1:0]  rdData1,
    output logic [WIDTH-1:0]  rdData2,
    output logic              ready
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic              dr_is_zero;
    logic              wr_hit;
    logic              byp1, byp2;

    assign dr_is_zero = (ZERO_R0 != 0) && (dr == '0);

    // A write lands only in READY, without a competing clear, and never into a hardwired r0.
    assign wr_hit = (state_q == ST_READY) && !clear && write && !dr_is_zero;

    // Controller: clear restarts the sweep, the sweep zeroes one entry per cycle, then writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        mem_d   = mem_q;
        if (clear) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            ready_d = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_d[cnt_q] = '0;
            cnt_d        = cnt_q + ADDR_W'(1);
            if (cnt_q == CNT_LAST) begin
                state_d = ST_READY;
                ready_d = 1'b1;
            end
        end else if (wr_hit) begin
            mem_d[dr] = wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Storage is left untouched by the reset edge itself; the sweep that follows zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

    assign byp1 = (BYPASS != 0) && ready_q && write && !clear && (dr == sr1);
    assign byp2 = (BYPASS != 0) && ready_q && write && !clear && (dr == sr2);

    always_comb begin
        rdData1 = '0;
        if ((ZERO_R0 != 0) && (sr1 == '0)) begin
            rdData1 = '0;
        end else if (!ready_q) begin
            rdData1 = '0;
        end else if (byp1) begin
            rdData1 = wrData;
        end else begin
            rdData1 = mem_q[sr1];
        end
    end

    always_comb begin
        rdData2 = '0;
        if ((ZERO_R0 != 0) && (sr2 == '0)) begin
            rdData2 = '0;
        end else if (!ready_q) begin
            rdData2 = '0;
        end else if (byp2) begin
            rdData2 = wrData;
        end else begin
            rdData2 = mem_q[sr2];
        end
    end

    assign ready = ready_q;

endmodule
